// File: rtl/ann_pkg.sv
// ---------------------------------------------------------------------------
// ann_pkg
//   Shared definitions for the neuron loader:
//   - loader FSM state encoding
//   - byte and result widths, timeout result code
//   - frame_len(): number of bytes in one frame (bias + N inputs + N weights)
// ---------------------------------------------------------------------------
package ann_pkg;

   localparam int BYTE_W = 8;
   localparam int RES_W  = 16;

   localparam logic [RES_W-1:0] RES_TIMEOUT = 16'hFFFF;

   typedef enum logic [2:0] {
      ST_LOAD    = 3'd0,
      ST_START   = 3'd1,
      ST_BUSY_LO = 3'd2,
      ST_BUSY_HI = 3'd3,
      ST_OUT     = 3'd4
   } state_e;

   // One bias byte, then N input bytes, then N weight bytes.
   function automatic int frame_len(input int n);
      return 2 * n + 1;
   endfunction

endpackage

// File: rtl/ann_frame_packer.sv
// ---------------------------------------------------------------------------
// ann_frame_packer
//   Byte index counter and slot write decode for one neuron frame.
//   Each accepted byte lands in the slot selected by the current index:
//   0 -> bias, 1..N -> input elements 0..N-1, N+1..2N -> weights 0..N-1.
//   The index wraps to 0 after the last byte, so the next frame always
//   starts at the bias slot. Slot registers only change on a write, so the
//   packed vectors stay stable while the neuron runs.
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   wr_en        a byte is accepted this cycle
//   wr_data      accepted byte
//   bias         bias register
//   input_vec    packed input elements, element 0 in bits [0:7]
//   weight_vec   packed weight elements, element 0 in bits [0:7]
//   last_byte    current index points at the final byte of the frame
// ---------------------------------------------------------------------------
module ann_frame_packer
   import ann_pkg::*;
#(
   parameter int N = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                wr_en,
   input  logic [BYTE_W-1:0]   wr_data,
   output logic [BYTE_W-1:0]   bias,
   output logic [0:BYTE_W*N-1] input_vec,
   output logic [0:BYTE_W*N-1] weight_vec,
   output logic                last_byte
);

   localparam int FRAME_LEN = frame_len(N);
   localparam int IDX_W     = $clog2(FRAME_LEN);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [BYTE_W-1:0] bias_q, bias_d;

   assign last_byte = (idx_q == LAST_IDX);
   assign bias      = bias_q;

   always_comb begin
      idx_d = idx_q;
      if (wr_en) begin
         idx_d = last_byte ? '0 : idx_q + 1'b1;
      end
   end

   always_comb begin
      bias_d = bias_q;
      if (wr_en && (idx_q == '0)) begin
         bias_d = wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q  <= '0;
         bias_q <= '0;
      end else begin
         idx_q  <= idx_d;
         bias_q <= bias_d;
      end
   end

   // One input slot and one weight slot per vector element.
   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_slot
         logic [BYTE_W-1:0] in_q, in_d;
         logic [BYTE_W-1:0] w_q, w_d;

         always_comb begin
            in_d = in_q;
            if (wr_en && (idx_q == IDX_W'(1 + gi))) begin
               in_d = wr_data;
            end
         end

         always_comb begin
            w_d = w_q;
            if (wr_en && (idx_q == IDX_W'(N + 1 + gi))) begin
               w_d = wr_data;
            end
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               in_q <= '0;
               w_q  <= '0;
            end else begin
               in_q <= in_d;
               w_q  <= w_d;
            end
         end

         assign input_vec[BYTE_W*gi +: BYTE_W]  = in_q;
         assign weight_vec[BYTE_W*gi +: BYTE_W] = w_q;
      end
   endgenerate

endmodule

// File: rtl/ann_loader.sv
// ---------------------------------------------------------------------------
// ann_loader
//   Host-side initiator for one neuron instance. Collects a frame of
//   2N+1 bytes (bias, inputs, weights), pulses nn_start, waits for the
//   neuron to drop and then raise nn_done, and returns nn_result on a
//   valid/ready output. If the neuron does not finish within TIMEOUT
//   cycles of a wait state, the frame is aborted with m_data=16'hFFFF and
//   err=1. Only one frame is in flight: s_ready is high in LOAD only.
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   s_valid/s_data/s_ready   input byte stream
//   nn_bias, nn_input_vec, nn_weight_vec   operands to the neuron
//   nn_start          one-cycle start pulse
//   nn_done           neuron done level (high when idle or finished)
//   nn_result         neuron result
//   m_valid/m_data/m_ready   result port
//   err               set with m_valid on timeout, cleared on handshake
// ---------------------------------------------------------------------------
module ann_loader
   import ann_pkg::*;
#(
   parameter int N       = 2,
   parameter int TIMEOUT = 1024
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                s_valid,
   input  logic [BYTE_W-1:0]   s_data,
   output logic                s_ready,
   output logic [BYTE_W-1:0]   nn_bias,
   output logic [0:BYTE_W*N-1] nn_input_vec,
   output logic [0:BYTE_W*N-1] nn_weight_vec,
   output logic                nn_start,
   input  logic                nn_done,
   input  logic [RES_W-1:0]    nn_result,
   output logic                m_valid,
   output logic [RES_W-1:0]    m_data,
   input  logic                m_ready,
   output logic                err
);

   localparam int TMO_W = $clog2(TIMEOUT + 1);
   // Abort on the TIMEOUT-th cycle spent in a wait state.
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

   state_e            state_q, state_d;
   logic [TMO_W-1:0]  tmo_q, tmo_d;
   logic              nn_start_q, nn_start_d;
   logic              m_valid_q, m_valid_d;
   logic [RES_W-1:0]  m_data_q, m_data_d;
   logic              err_q, err_d;

   logic              accept;
   logic              last_byte;

   assign s_ready  = (state_q == ST_LOAD);
   assign accept   = s_valid & s_ready;
   assign nn_start = nn_start_q;
   assign m_valid  = m_valid_q;
   assign m_data   = m_data_q;
   assign err      = err_q;

   ann_frame_packer #(
      .N (N)
   ) u_packer (
      .clk        (clk),
      .rst_n      (rst_n),
      .wr_en      (accept),
      .wr_data    (s_data),
      .bias       (nn_bias),
      .input_vec  (nn_input_vec),
      .weight_vec (nn_weight_vec),
      .last_byte  (last_byte)
   );

   always_comb begin
      state_d    = state_q;
      tmo_d      = tmo_q;
      nn_start_d = 1'b0;
      m_valid_d  = m_valid_q;
      m_data_d   = m_data_q;
      err_d      = err_q;

      case (state_q)
         ST_LOAD: begin
            if (accept && last_byte) begin
               // Start is registered so it appears in the START cycle.
               state_d    = ST_START;
               nn_start_d = 1'b1;
            end
         end

         ST_START: begin
            state_d = ST_BUSY_LO;
            tmo_d   = '0;
         end

         // nn_done is high while the neuron is idle, so a low level is the
         // only reliable sign that it has taken the start pulse.
         ST_BUSY_LO: begin
            if (!nn_done) begin
               state_d = ST_BUSY_HI;
               tmo_d   = '0;
            end else if (tmo_q == TMO_LAST) begin
               state_d   = ST_OUT;
               m_data_d  = RES_TIMEOUT;
               m_valid_d = 1'b1;
               err_d     = 1'b1;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end

         ST_BUSY_HI: begin
            if (nn_done) begin
               state_d   = ST_OUT;
               m_data_d  = nn_result;
               m_valid_d = 1'b1;
            end else if (tmo_q == TMO_LAST) begin
               state_d   = ST_OUT;
               m_data_d  = RES_TIMEOUT;
               m_valid_d = 1'b1;
               err_d     = 1'b1;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end

         ST_OUT: begin
            if (m_ready) begin
               state_d   = ST_LOAD;
               m_valid_d = 1'b0;
               err_d     = 1'b0;
            end
         end

         default: begin
            state_d = ST_LOAD;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_LOAD;
         tmo_q      <= '0;
         nn_start_q <= 1'b0;
         m_valid_q  <= 1'b0;
         m_data_q   <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         tmo_q      <= tmo_d;
         nn_start_q <= nn_start_d;
         m_valid_q  <= m_valid_d;
         m_data_q   <= m_data_d;
         err_q      <= err_d;
      end
   end

endmodule

// File: tb/tb_ann_loader.sv
// ---------------------------------------------------------------------------
// tb_ann_loader
//   Directed bench for ann_loader (N=2, TIMEOUT=16) with a behavioural
//   neuron: result = bias + in0*w0 + in1*w1, nn_done low for 4 cycles
//   after a start pulse (or forever when hang is set).
// ---------------------------------------------------------------------------
module tb_ann_loader;

   localparam int N       = 2;
   localparam int TIMEOUT = 16;

   logic              clk     = 1'b0;
   logic              rst_n   = 1'b0;
   logic              s_valid = 1'b0;
   logic [7:0]        s_data  = 8'h00;
   logic              s_ready;
   logic [7:0]        nn_bias;
   logic [0:8*N-1]    nn_input_vec;
   logic [0:8*N-1]    nn_weight_vec;
   logic              nn_start;
   logic              nn_done;
   logic [15:0]       nn_result;
   logic              m_valid;
   logic [15:0]       m_data;
   logic              m_ready = 1'b0;
   logic              err;

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   ann_loader #(
      .N       (N),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .s_valid       (s_valid),
      .s_data        (s_data),
      .s_ready       (s_ready),
      .nn_bias       (nn_bias),
      .nn_input_vec  (nn_input_vec),
      .nn_weight_vec (nn_weight_vec),
      .nn_start      (nn_start),
      .nn_done       (nn_done),
      .nn_result     (nn_result),
      .m_valid       (m_valid),
      .m_data        (m_data),
      .m_ready       (m_ready),
      .err           (err)
   );

   // ---------------- behavioural neuron ----------------
   logic        model_done = 1'b1;
   logic [15:0] model_res  = 16'h0000;
   int          model_cnt  = 0;
   bit          hang       = 1'b0;

   assign nn_done   = model_done;
   assign nn_result = model_res;

   always @(posedge clk) begin
      if (nn_start) begin
         model_done <= 1'b0;
         model_cnt  <= 4;
      end else if (!model_done && !hang) begin
         if (model_cnt == 1) begin
            model_done <= 1'b1;
            model_res  <= 16'(nn_bias)
                        + 16'(nn_input_vec[0:7])  * 16'(nn_weight_vec[0:7])
                        + 16'(nn_input_vec[8:15]) * 16'(nn_weight_vec[8:15]);
         end else begin
            model_cnt <= model_cnt - 1;
         end
      end
   end

   // ---------------- monitor for the back-to-back test ----------------
   bit          mon_en = 1'b0;
   int          starts = 0;
   logic [15:0] resq[$];

   always @(negedge clk) begin
      if (mon_en) begin
         if (nn_start) starts++;
         if (m_valid && m_ready) resq.push_back(m_data);
      end
   end

   // ---------------- helpers ----------------
   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   // Drive one byte from a negedge; waits (bounded) for s_ready, then lets
   // the accepting edge pass and returns at the following negedge.
   task automatic send(input logic [7:0] b);
      int w = 0;
      s_valid = 1'b1;
      s_data  = b;
      while (!s_ready && w < 200) begin
         @(negedge clk);
         w++;
      end
      if (w >= 200) check("send_wait_sready", 16'(s_ready), 16'd1);
      @(posedge clk);
      @(negedge clk);
      s_valid = 1'b0;
      $display("byte %02h accepted", b);
   endtask

   task automatic send_frame(input logic [7:0] b0, b1, b2, b3, b4, input bit gaps);
      logic [7:0] fr [5];
      fr[0] = b0; fr[1] = b1; fr[2] = b2; fr[3] = b3; fr[4] = b4;
      for (int i = 0; i < 5; i++) begin
         send(fr[i]);
         if (gaps && i < 4) @(negedge clk);
      end
   endtask

   // Counts negedges until m_valid (bounded); records any s_ready seen high.
   task automatic wait_result(output int cyc, output bit sready_seen);
      cyc = 0;
      sready_seen = 1'b0;
      while (!m_valid && cyc < 100) begin
         @(negedge clk);
         cyc++;
         if (s_ready) sready_seen = 1'b1;
      end
   endtask

   task automatic handshake();
      m_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      m_ready = 1'b0;
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int cyc;
      bit seen;
      bit stable;
      int w;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_s_ready", 16'(s_ready), 16'd1);
      check("rst_m_valid", 16'(m_valid), 16'd0);
      check("rst_start",   16'(nn_start), 16'd0);
      check("rst_err",     16'(err), 16'd0);
      check("rst_m_data",  m_data, 16'h0000);
      check("rst_bias",    16'(nn_bias), 16'h0000);
      rst_n = 1'b1;
      @(negedge clk);

      // 1. back-to-back frame: 5 + 1*3 + 2*4 = 16
      send_frame(8'h05, 8'h01, 8'h02, 8'h03, 8'h04, 1'b0);
      check("t1_start",   16'(nn_start), 16'd1);
      check("t1_bias",    16'(nn_bias), 16'h0005);
      check("t1_invec",   nn_input_vec, 16'h0102);
      check("t1_wvec",    nn_weight_vec, 16'h0304);
      check("t1_sready",  16'(s_ready), 16'd0);
      @(negedge clk);
      check("t1_start_1cyc", 16'(nn_start), 16'd0);
      wait_result(cyc, seen);
      check("t1_latency", 16'(cyc), 16'd5);
      check("t1_sready_busy", 16'(seen), 16'd0);
      check("t1_m_data",  m_data, 16'h0010);
      check("t1_err",     16'(err), 16'd0);
      handshake();
      $display("t1 result %04h", 16'h0010);
      check("t1_post_sready", 16'(s_ready), 16'd1);
      check("t1_post_mvalid", 16'(m_valid), 16'd0);

      // 2. same frame with idle cycles between bytes
      send_frame(8'h05, 8'h01, 8'h02, 8'h03, 8'h04, 1'b1);
      check("t2_start",  16'(nn_start), 16'd1);
      check("t2_bias",   16'(nn_bias), 16'h0005);
      check("t2_invec",  nn_input_vec, 16'h0102);
      check("t2_wvec",   nn_weight_vec, 16'h0304);
      wait_result(cyc, seen);
      check("t2_sready_busy", 16'(seen), 16'd0);
      check("t2_m_data", m_data, 16'h0010);
      handshake();
      check("t2_post_sready", 16'(s_ready), 16'd1);

      // 3. output back-pressure for 10 cycles
      send_frame(8'h05, 8'h01, 8'h02, 8'h03, 8'h04, 1'b0);
      wait_result(cyc, seen);
      stable = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (!(m_valid === 1'b1 && m_data === 16'h0010 && s_ready === 1'b0)) stable = 1'b0;
      end
      check("t3_hold_stable", 16'(stable), 16'd1);
      check("t3_m_data", m_data, 16'h0010);
      handshake();
      check("t3_load_after_hs", 16'(s_ready), 16'd1);
      check("t3_mvalid_after_hs", 16'(m_valid), 16'd0);

      // 4. neuron never finishes: abort after TIMEOUT cycles in BUSY_HI
      hang = 1'b1;
      send_frame(8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 1'b0);
      @(negedge clk);
      wait_result(cyc, seen);
      check("t4_latency", 16'(cyc), 16'd17);
      check("t4_m_data",  m_data, 16'hFFFF);
      check("t4_err",     16'(err), 16'd1);
      handshake();
      check("t4_err_clr", 16'(err), 16'd0);
      check("t4_sready",  16'(s_ready), 16'd1);
      hang = 1'b0;
      repeat (8) @(negedge clk);

      // 5. reset in mid-frame; 2 + 3*5 + 4*6 = 41
      send(8'h09);
      send(8'h09);
      send(8'h09);
      rst_n = 1'b0;
      #1;
      check("t5_rst_bias",   16'(nn_bias), 16'h0000);
      check("t5_rst_invec",  nn_input_vec, 16'h0000);
      check("t5_rst_m_data", m_data, 16'h0000);
      check("t5_rst_sready", 16'(s_ready), 16'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      send_frame(8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 1'b0);
      check("t5_bias",  16'(nn_bias), 16'h0002);
      check("t5_invec", nn_input_vec, 16'h0304);
      check("t5_wvec",  nn_weight_vec, 16'h0506);
      wait_result(cyc, seen);
      check("t5_m_data", m_data, 16'h0029);
      handshake();

      // 6. two frames back-to-back with m_ready held high
      starts = 0;
      resq.delete();
      mon_en  = 1'b1;
      m_ready = 1'b1;
      send_frame(8'h05, 8'h01, 8'h02, 8'h03, 8'h04, 1'b0);
      send_frame(8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 1'b0);
      w = 0;
      while (resq.size() < 2 && w < 200) begin
         @(negedge clk);
         w++;
      end
      repeat (3) @(negedge clk);
      mon_en  = 1'b0;
      m_ready = 1'b0;
      check("t6_count",  16'(resq.size()), 16'd2);
      check("t6_starts", 16'(starts), 16'd2);
      if (resq.size() >= 2) begin
         $display("t6 results %04h %04h", resq[0], resq[1]);
         check("t6_res0", resq[0], 16'h0010);
         check("t6_res1", resq[1], 16'h0029);
      end
      check("t6_sready", 16'(s_ready), 16'd1);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
